// File: rtl/gcn_transform_ctrl.sv
// GCN transformation-stage controller: fetches weights and features,
// steers the dot-product unit and issues one buffer write per result.
module gcn_transform_ctrl #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int FEATURE_BASE          = 512,
  parameter int DP_LATENCY            = 1,
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             enable_read,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             load_weight,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_idx,
  output logic                             load_feature,
  output logic                             dp_clear,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_sel,
  output logic                             write_enable,
  output logic [COUNTER_FEATURE_WIDTH-1:0] write_row,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  write_col,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = COUNTER_WEIGHT_WIDTH;
  localparam int FW = COUNTER_FEATURE_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int LW = $clog2(DP_LATENCY + 1);

  localparam logic [CW-1:0] W_LAST = CW'(WEIGHT_COLS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FEATURE_ROWS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(DP_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_W,
    S_READ_F,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_w_cnt;
  logic [FW-1:0] r_f_cnt;
  logic [CW-1:0] r_c_cnt;
  logic [LW-1:0] r_l_cnt;

  logic [AW-1:0] w_faddr;
  logic          w_lat_end;

  assign w_faddr   = AW'(FEATURE_BASE) + AW'(r_f_cnt);
  assign w_lat_end = (r_l_cnt == L_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_w_cnt <= '0;
      r_f_cnt <= '0;
      r_c_cnt <= '0;
      r_l_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ_W;
            r_w_cnt <= '0;
          end
        end
        S_READ_W: begin
          if (r_w_cnt == W_LAST) begin
            r_state <= S_READ_F;
            r_f_cnt <= '0;
          end else begin
            r_w_cnt <= r_w_cnt + CW'(1);
          end
        end
        S_READ_F: begin
          r_state <= S_COMPUTE;
          r_c_cnt <= '0;
          r_l_cnt <= '0;
        end
        S_COMPUTE: begin
          if (w_lat_end) begin
            r_l_cnt <= '0;
            if (r_c_cnt != W_LAST) begin
              r_c_cnt <= r_c_cnt + CW'(1);
            end else if (r_f_cnt != F_LAST) begin
              r_f_cnt <= r_f_cnt + FW'(1);
              r_state <= S_READ_F;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_l_cnt <= r_l_cnt + LW'(1);
          end
        end
        S_DONE: begin
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; the feature address stays on the bus through COMPUTE
  always_comb begin
    enable_read  = 1'b0;
    read_address = '0;
    load_weight  = 1'b0;
    weight_idx   = '0;
    load_feature = 1'b0;
    dp_clear     = 1'b0;
    weight_sel   = '0;
    write_enable = 1'b0;
    write_row    = '0;
    write_col    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_READ_W: begin
        enable_read  = 1'b1;
        read_address = AW'(r_w_cnt);
        load_weight  = 1'b1;
        weight_idx   = r_w_cnt;
        busy         = 1'b1;
      end
      S_READ_F: begin
        enable_read  = 1'b1;
        read_address = w_faddr;
        load_feature = 1'b1;
        busy         = 1'b1;
      end
      S_COMPUTE: begin
        read_address = w_faddr;
        weight_sel   = r_c_cnt;
        dp_clear     = (r_l_cnt == '0);
        busy         = 1'b1;
        if (w_lat_end) begin
          write_enable = 1'b1;
          write_row    = r_f_cnt;
          write_col    = r_c_cnt;
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/gcn_transform_ctrl.md
# gcn_transform_ctrl

Control FSM for the GCN transformation stage (feature matrix × weight matrix). It performs the following sequence:
- Fetch every weight column, then each feature row, from the shared read port (`read_address` / `enable_read` / `data_in`).
- Steer the dot-product unit across the weight columns.
- Issue one write per result into the FM×WM buffer.
- Signal `done` so the aggregation/argmax stage can begin.

The block sits between the external memory port and the transformation datapath inside `GCN`.

## Interface
- `FEATURE_ROWS`, 6: nodes / feature rows to process.
- `WEIGHT_COLS`, 3: weight columns (output classes).
- `ADDRESS_WIDTH`, 13: read address width.
- `FEATURE_BASE`, 512: address of feature row 0; weight column c is at address c.
- `DP_LATENCY`, 1: cycles the dot-product unit needs per column (≥1).
- `COUNTER_WEIGHT_WIDTH`, $clog2(WEIGHT_COLS): column index width.
- `COUNTER_FEATURE_WIDTH`, $clog2(FEATURE_ROWS): row index width.
- `clk`, in, 1: clock. One clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: level request; sampled only in IDLE.
- `enable_read`, out, 1: memory read strobe. Memory returns `data_in` combinationally in the same cycle.
- `read_address`, out, ADDRESS_WIDTH: memory address.
- `load_weight`, out, 1: datapath captures `data_in` as weight column `weight_idx` at the next edge.
- `weight_idx`, out, COUNTER_WEIGHT_WIDTH: column being loaded.
- `load_feature`, out, 1: datapath captures `data_in` as the current feature row.
- `dp_clear`, out, 1: clear the dot-product accumulator (first compute cycle of each column).
- `weight_sel`, out, COUNTER_WEIGHT_WIDTH: weight column feeding the dot-product unit.
- `write_enable`, out, 1: write the dot product into buffer[`write_row`][`write_col`].
- `write_row`, out, COUNTER_FEATURE_WIDTH; `write_col`, out, COUNTER_WEIGHT_WIDTH.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `done`, out, 1: all FEATURE_ROWS×WEIGHT_COLS results are written.

## Operation
- State and counter registers: w_cnt (column), f_cnt (row), c_cnt (compute column), l_cnt (latency, $clog2(DP_LATENCY+1) bits).
- All outputs are decoded from registered state and counters (Moore), with no path from `start` to any output.
- IDLE: all outputs 0. If `start`=1, go to READ_W with w_cnt=0.
- READ_W: `enable_read`=1, `read_address`=w_cnt, `load_weight`=1, `weight_idx`=w_cnt.
  - If w_cnt==WEIGHT_COLS-1, go to READ_F with f_cnt=0.
  - Otherwise w_cnt++.
- READ_F: `enable_read`=1, `read_address`=FEATURE_BASE+f_cnt, `load_feature`=1. Go to COMPUTE with c_cnt=0, l_cnt=0.
- COMPUTE: `weight_sel`=c_cnt, `enable_read`=0, `read_address` holds its last value.
  - `dp_clear`=1 when l_cnt==0.
  - When l_cnt==DP_LATENCY-1: `write_enable`=1, `write_row`=f_cnt, `write_col`=c_cnt, then l_cnt=0 and:
    - if c_cnt<WEIGHT_COLS-1: c_cnt++;
    - else if f_cnt<FEATURE_ROWS-1: f_cnt++, go to READ_F;
    - else go to DONE.
  - Otherwise l_cnt++.
- DONE: `done`=1 and holds. Go to IDLE when `start`=0.
  - `start` held high keeps the block in DONE, so there is no automatic re-run.
- Address arithmetic: FEATURE_BASE+f_cnt, zero-extended to ADDRESS_WIDTH. The weight address is w_cnt, zero-extended.
- When `write_enable` is low, `write_row` and `write_col` are 0.
- Counters never wrap: every limit is compared with ==, not by overflow.

## Timing
- Reset: state=IDLE, all counters 0, and every output (`enable_read`, `read_address`, `load_*`, `weight_idx`, `dp_clear`, `weight_sel`, `write_*`, `busy`, `done`) is 0 after the reset edge.
- `reset` has priority over all transitions. Asserting it mid-run aborts at the next edge with no further write. A run restarts only from IDLE.
- `start` changes while `busy`=1 are ignored.
- Latency: `start` sampled at edge 0 makes cycle 1 the first READ_W cycle. `done` first reads 1 in cycle 1 + WEIGHT_COLS + FEATURE_ROWS×(1+WEIGHT_COLS×DP_LATENCY).
  - Defaults: cycle 28.
  - DP_LATENCY=2: cycle 46.
- Exactly FEATURE_ROWS×WEIGHT_COLS `write_enable` pulses per run, each exactly one cycle, ordered row-major.
- Exactly WEIGHT_COLS+FEATURE_ROWS `enable_read` cycles per run.

## Test plan
- Reset then `start`=1 with defaults. Expect:
  - `read_address` in cycles 1–3 = 0, 1, 2 with `load_weight`;
  - cycle 4 = 512 with `load_feature`;
  - cycle 8 = 513;
  - `done` first reads 1 in cycle 28;
  - 18 writes, (0,0) through (5,2), in order.
- DP_LATENCY=3. Expect `dp_clear` in the first cycle and `write_enable` in the third cycle of each column, and `done` in cycle 64.
- Full datapath hooked up with memory models loaded from feature_data/weight_data. Each buffer entry must equal the reference integer dot product.
- Assert `reset` in the cycle of the 5th write. Expect all outputs 0 on the next cycle and no further writes. Re-asserting `start` reruns the full 18-write sequence from address 0.
- Toggle `start` 1→0→1 while busy. Expect no effect on the sequence or write count.
- Hold `start`=1 after `done`. Expect `done` to stay 1 and no reads. Drop `start`: next cycle is IDLE with `done`=0. A new `start` performs a second identical run.
